// File: rtl/decoder_onehot_seq.sv
// Registered binary-to-one-hot decoder with a valid/ready request port,
// out-of-range error pulse and an auto-scan mode with programmable dwell.
module decoder_onehot_seq #(
    parameter int SEL_W   = 3,
    parameter int OUT_W   = 8,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   sel,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               stop,
    output logic [OUT_W-1:0]   data_out,
    output logic               out_valid,
    output logic               err,
    output logic               wrap,
    output logic               busy
);

    typedef enum logic {IDLE, SCAN} state_t;

    // One extra bit so the limit compare also works when OUT_W == 2**SEL_W.
    localparam logic [SEL_W:0]   OUT_LIM = (SEL_W + 1)'(OUT_W);
    localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(OUT_W - 1);

    state_t             state;
    logic [SEL_W-1:0]   idx;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_q;
    logic               sel_oor;
    logic               accept;

    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i_sel);
        logic [OUT_W-1:0] o;
        o = '0;
        for (int i = 0; i < OUT_W; i++) begin
            o[i] = (i_sel == SEL_W'(i));
        end
        return o;
    endfunction

    assign in_ready = en && (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign sel_oor  = ({1'b0, sel} >= OUT_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            dwell_q   <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            wrap      <= 1'b0;
            busy      <= 1'b0;
        end else if (!en) begin
            err  <= 1'b0;
            wrap <= 1'b0;
        end else begin
            err  <= 1'b0;
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (sel_oor) begin
                            data_out  <= '0;
                            out_valid <= 1'b0;
                            err       <= 1'b1;
                        end else if (mode) begin
                            state     <= SCAN;
                            busy      <= 1'b1;
                            idx       <= sel;
                            cnt       <= '0;
                            dwell_q   <= dwell;
                            data_out  <= onehot(sel);
                            out_valid <= 1'b1;
                        end else begin
                            data_out  <= onehot(sel);
                            out_valid <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    // stop wins over an advance or wrap due on the same edge
                    if (stop) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        data_out  <= '0;
                        out_valid <= 1'b0;
                        cnt       <= '0;
                    end else if (cnt == dwell_q) begin
                        cnt <= '0;
                        if (idx == IDX_MAX) begin
                            idx      <= '0;
                            wrap     <= 1'b1;
                            data_out <= onehot('0);
                        end else begin
                            idx      <= idx + SEL_W'(1);
                            data_out <= onehot(idx + SEL_W'(1));
                        end
                    end else begin
                        cnt <= cnt + DWELL_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Scoreboard bench for decoder_onehot_seq: an 8-output and a 6-output instance,
// expected output changes queued at issue time and checked by per-instance monitors.
module tb_decoder_onehot_seq;

    typedef struct packed {
        logic [31:0] cyc;
        logic [11:0] v;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b1;
    logic       mode = 1'b0;
    logic       in_valid8 = 1'b0;
    logic       in_valid6 = 1'b0;
    logic [2:0] sel = '0;
    logic [7:0] dwell = '0;
    logic       stop = 1'b0;

    logic       in_ready8, ov8, err8, wrap8, busy8;
    logic [7:0] dout8;
    logic       in_ready6, ov6, err6, wrap6, busy6;
    logic [5:0] dout6;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    rec_t exp8[$];
    rec_t exp6[$];

    decoder_onehot_seq #(.SEL_W(3), .OUT_W(8), .DWELL_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid8),
        .in_ready(in_ready8), .sel(sel), .dwell(dwell), .stop(stop),
        .data_out(dout8), .out_valid(ov8), .err(err8), .wrap(wrap8), .busy(busy8)
    );

    decoder_onehot_seq #(.SEL_W(3), .OUT_W(6), .DWELL_W(8)) u6 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid6),
        .in_ready(in_ready6), .sel(sel), .dwell(dwell), .stop(stop),
        .data_out(dout6), .out_valid(ov6), .err(err6), .wrap(wrap6), .busy(busy6)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] vec(input logic [7:0] d, input bit ov, input bit er,
                                        input bit wr, input bit bz);
        return {d, ov, er, wr, bz};
    endfunction

    function automatic void push8(input int c, input logic [7:0] d, input bit ov,
                                  input bit er, input bit wr, input bit bz);
        exp8.push_back({c[31:0], vec(d, ov, er, wr, bz)});
    endfunction

    function automatic void push6(input int c, input logic [7:0] d, input bit ov,
                                  input bit er, input bit wr, input bit bz);
        exp6.push_back({c[31:0], vec(d, ov, er, wr, bz)});
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic mon_cmp(input string nm, input bit have, input rec_t r, input logic [11:0] v);
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL %s unexpected change: got cyc=%0d vec=%h, expected no change", nm, cyc, v);
        end else if (r.v !== v || r.cyc != cyc) begin
            errors++;
            $display("FAIL %s: got cyc=%0d vec=%h, expected cyc=%0d vec=%h", nm, cyc, v, r.cyc, r.v);
        end
    endtask

    // Monitors: every change of {data_out, out_valid, err, wrap, busy} consumes one record.
    logic [11:0] prev8 = '0, prev6 = '0, cur8, cur6;
    rec_t        r8, r6;
    bit          h8, h6;

    always @(negedge clk) begin
        cur8 = vec(dout8, ov8, err8, wrap8, busy8);
        if (cur8 !== prev8) begin
            prev8 = cur8;
            h8 = (exp8.size() != 0);
            r8 = h8 ? exp8.pop_front() : '0;
            mon_cmp("mon8", h8, r8, cur8);
        end
    end

    always @(negedge clk) begin
        cur6 = vec({2'b00, dout6}, ov6, err6, wrap6, busy6);
        if (cur6 !== prev6) begin
            prev6 = cur6;
            h6 = (exp6.size() != 0);
            r6 = h6 ? exp6.pop_front() : '0;
            mon_cmp("mon6", h6, r6, cur6);
        end
    end

    // Present a request at a negedge; c is the clock edge that accepts it.
    task automatic issue(input bit to6, input bit m, input logic [2:0] s,
                         input logic [7:0] dw, output int c);
        @(negedge clk);
        mode  = m;
        sel   = s;
        dwell = dw;
        if (to6) in_valid6 = 1'b1;
        else     in_valid8 = 1'b1;
        c = cyc + 1;
        chk(to6 ? "in_ready6_at_req" : "in_ready8_at_req", to6 ? in_ready6 : in_ready8, 1);
    endtask

    task automatic drop_req();
        @(negedge clk);
        in_valid8 = 1'b0;
        in_valid6 = 1'b0;
    endtask

    initial begin
        int c;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_dout8", dout8, 0);
        chk("rst_ov8", ov8, 0);
        chk("rst_err8", err8, 0);
        chk("rst_wrap8", wrap8, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_dout6", dout6, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready8", in_ready8, 1);
        chk("rst_in_ready6", in_ready6, 1);

        // Direct decode on the 8-output instance, sel 0..7.
        for (int i = 0; i < 8; i++) begin
            issue(0, 0, 3'(i), 8'd0, c);
            push8(c, 8'(1 << i), 1, 0, 0, 0);
            drop_req();
        end

        // Out-of-range on the 6-output instance, both modes; then legal decode and a wrapping scan.
        issue(1, 0, 3'd6, 8'd0, c);
        push6(c, 8'h00, 0, 1, 0, 0);
        push6(c + 1, 8'h00, 0, 0, 0, 0);
        drop_req();
        issue(1, 1, 3'd7, 8'd0, c);
        push6(c, 8'h00, 0, 1, 0, 0);
        push6(c + 1, 8'h00, 0, 0, 0, 0);
        drop_req();
        issue(1, 0, 3'd5, 8'd0, c);
        push6(c, 8'h20, 1, 0, 0, 0);
        drop_req();
        issue(1, 1, 3'd4, 8'd0, c);
        push6(c, 8'h10, 1, 0, 0, 1);
        push6(c + 1, 8'h20, 1, 0, 0, 1);
        push6(c + 2, 8'h01, 1, 0, 1, 1);
        push6(c + 3, 8'h02, 1, 0, 0, 1);
        push6(c + 4, 8'h00, 0, 0, 0, 0);
        drop_req();
        repeat (3) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        #1 chk("in_ready6_after_stop", in_ready6, 1);

        // Scan from 6 with dwell 2, including an ignored request mid-scan.
        issue(0, 1, 3'd6, 8'd2, c);
        push8(c, 8'h40, 1, 0, 0, 1);
        push8(c + 3, 8'h80, 1, 0, 0, 1);
        push8(c + 6, 8'h01, 1, 0, 1, 1);
        push8(c + 7, 8'h01, 1, 0, 0, 1);
        push8(c + 8, 8'h00, 0, 0, 0, 0);
        drop_req();
        chk("in_ready8_scan", in_ready8, 0);
        mode = 1'b0;
        sel = 3'd2;
        in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (6) begin
            chk("in_ready8_scan", in_ready8, 0);
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        #1 chk("in_ready8_after_stop", in_ready8, 1);

        // Stop on the wrap edge with dwell 0.
        issue(0, 1, 3'd7, 8'd0, c);
        push8(c, 8'h80, 1, 0, 0, 1);
        push8(c + 1, 8'h00, 0, 0, 0, 0);
        drop_req();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        #1 chk("in_ready8_stop_wrap", in_ready8, 1);

        // Enable freeze mid-dwell: advance delayed by exactly 5 cycles.
        issue(0, 1, 3'd2, 8'd3, c);
        push8(c, 8'h04, 1, 0, 0, 1);
        push8(c + 9, 8'h08, 1, 0, 0, 1);
        push8(c + 10, 8'h00, 0, 0, 0, 0);
        drop_req();
        repeat (2) @(negedge clk);
        en = 1'b0;
        #1 chk("in_ready8_en0", in_ready8, 0);
        repeat (5) begin
            @(negedge clk);
            #1 chk("in_ready8_en0", in_ready8, 0);
        end
        en = 1'b1;
        repeat (2) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;

        // Asynchronous reset between edges mid-scan.
        issue(0, 1, 3'd1, 8'd5, c);
        push8(c, 8'h02, 1, 0, 0, 1);
        push8(c + 1, 8'h00, 0, 0, 0, 0);
        drop_req();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dout8", dout8, 0);
        chk("arst_ov8", ov8, 0);
        chk("arst_busy8", busy8, 0);
        chk("arst_wrap8", wrap8, 0);
        chk("arst_err8", err8, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 chk("arst_in_ready8", in_ready8, 1);
        issue(0, 0, 3'd3, 8'd0, c);
        push8(c, 8'h08, 1, 0, 0, 0);
        drop_req();

        repeat (4) @(negedge clk);
        chk("exp8_drained", exp8.size(), 0);
        chk("exp6_drained", exp6.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
